// File: rtl/entropy_class_tracker.sv
// Registered LOW/MID/CRIT classifier for entropy scores with hysteresis, dwell debounce and sticky alarm.
// Optional peak-score register enabled by defining ENTROPY_PEAK_TRACK_EN.
module entropy_class_tracker #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned HYST    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] entropy_in,
  input  logic [DATA_W-1:0] thr_mid,
  input  logic [DATA_W-1:0] thr_crit,
  input  logic [DWELL_W-1:0] dwell_cfg,
  input  logic              alarm_clr,
  output logic [1:0]        raw_class,
  output logic [1:0]        signal_class,
  output logic              class_chg,
  output logic              crit_alarm,
  output logic [DATA_W-1:0] peak_entropy
);

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_MID  = 2'b01,
    S_CRIT = 2'b10
  } state_t;

  localparam logic [DATA_W-1:0] HYST_V = DATA_W'(HYST);

  state_t             state_q, state_d;
  state_t             pend_q, pend_d;
  logic [DWELL_W:0]   count_q, count_d;
  logic [1:0]         raw_q, raw_d;
  logic               chg_q, chg_d;
  logic               alarm_q, alarm_d;

  state_t             cand;
  state_t             raw_now;
  logic [DATA_W-1:0]  eff_mid, eff_crit;
  logic [DWELL_W:0]   run;
  logic [DWELL_W:0]   need;

  function automatic logic [DATA_W-1:0] sat0(input logic [DATA_W-1:0] t);
    return (t > HYST_V) ? t - HYST_V : '0;
  endfunction

  always_comb begin
    eff_mid  = (state_q != S_LOW)  ? sat0(thr_mid)  : thr_mid;
    eff_crit = (state_q == S_CRIT) ? sat0(thr_crit) : thr_crit;

    if (entropy_in <= eff_mid)       cand = S_LOW;
    else if (entropy_in <= eff_crit) cand = S_MID;
    else                             cand = S_CRIT;

    if (entropy_in <= thr_mid)       raw_now = S_LOW;
    else if (entropy_in <= thr_crit) raw_now = S_MID;
    else                             raw_now = S_CRIT;

    // A run only extends while the same candidate keeps arriving; anything else restarts at 1.
    run  = (cand == pend_q) ? count_q + (DWELL_W+1)'(1) : (DWELL_W+1)'(1);
    need = {1'b0, dwell_cfg} + (DWELL_W+1)'(1);

    state_d = state_q;
    pend_d  = pend_q;
    count_d = count_q;
    raw_d   = raw_q;
    chg_d   = 1'b0;
    alarm_d = alarm_q & ~alarm_clr;

    if (sample_valid) begin
      raw_d = raw_now;
      if (cand == state_q) begin
        count_d = '0;
      end else if (run >= need) begin
        state_d = cand;
        count_d = '0;
        chg_d   = 1'b1;
        if (cand == S_CRIT) alarm_d = 1'b1;
      end else begin
        pend_d  = cand;
        count_d = run;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOW;
      pend_q  <= S_LOW;
      count_q <= '0;
      raw_q   <= '0;
      chg_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      raw_q   <= raw_d;
      chg_q   <= chg_d;
      alarm_q <= alarm_d;
    end
  end

  assign raw_class    = raw_q;
  assign signal_class = state_q;
  assign class_chg    = chg_q;
  assign crit_alarm   = alarm_q;

`ifdef ENTROPY_PEAK_TRACK_EN
  logic [DATA_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (alarm_clr)
      peak_d = sample_valid ? entropy_in : '0;
    else if (sample_valid && (entropy_in > peak_q))
      peak_d = entropy_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak_entropy = peak_q;
`else
  assign peak_entropy = '0;
`endif

endmodule

// File: tb/tb_entropy_class_tracker.sv
// Directed self-checking bench for entropy_class_tracker (default parameters).
module tb_entropy_class_tracker;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [7:0] entropy_in;
  logic [7:0] thr_mid;
  logic [7:0] thr_crit;
  logic [3:0] dwell_cfg;
  logic       alarm_clr;
  logic [1:0] raw_class;
  logic [1:0] signal_class;
  logic       class_chg;
  logic       crit_alarm;
  logic [7:0] peak_entropy;

  int unsigned n_tests;
  int unsigned n_fail;

  entropy_class_tracker #(.DATA_W(8), .DWELL_W(4), .HYST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .entropy_in   (entropy_in),
    .thr_mid      (thr_mid),
    .thr_crit     (thr_crit),
    .dwell_cfg    (dwell_cfg),
    .alarm_clr    (alarm_clr),
    .raw_class    (raw_class),
    .signal_class (signal_class),
    .class_chg    (class_chg),
    .crit_alarm   (crit_alarm),
    .peak_entropy (peak_entropy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: apply inputs at negedge, return just after the rising edge.
  task automatic drive(input logic v, input logic [7:0] x, input logic clr);
    @(negedge clk);
    sample_valid = v;
    entropy_in   = x;
    alarm_clr    = clr;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    alarm_clr    = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] cls, input logic chg, input logic alm);
    check({tag, "_class"}, 32'(signal_class), 32'(cls));
    check({tag, "_chg"},   32'(class_chg),    32'(chg));
    check({tag, "_alarm"}, 32'(crit_alarm),   32'(alm));
  endtask

  function automatic logic [7:0] pk(input logic [7:0] v);
`ifdef ENTROPY_PEAK_TRACK_EN
    return v;
`else
    return 8'd0 & v;
`endif
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    sample_valid = 1'b0;
    entropy_in = 8'd0;
    thr_mid = 8'd85;
    thr_crit = 8'd170;
    dwell_cfg = 4'd0;
    alarm_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst", 2'd0, 1'b0, 1'b0);
    check("rst_raw",  32'(raw_class),    32'd0);
    check("rst_peak", 32'(peak_entropy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic ladder, dwell 0
    drive(1'b1, 8'd80, 1'b0);
    expect_out("s80", 2'd0, 1'b0, 1'b0);
    check("s80_raw", 32'(raw_class), 32'd0);
    drive(1'b1, 8'd86, 1'b0);
    expect_out("s86", 2'd1, 1'b1, 1'b0);
    check("s86_raw", 32'(raw_class), 32'd1);
    drive(1'b1, 8'd171, 1'b0);
    expect_out("s171", 2'd2, 1'b1, 1'b1);
    check("s171_raw", 32'(raw_class), 32'd2);
    drive(1'b0, 8'd0, 1'b0);
    expect_out("idle", 2'd2, 1'b0, 1'b1);
    check("idle_raw", 32'(raw_class), 32'd2);

    // Hysteresis: CRIT -> MID on 100, 83 holds MID (raw LOW), 81 drops to LOW
    drive(1'b1, 8'd100, 1'b0);
    expect_out("c2m", 2'd1, 1'b1, 1'b1);
    drive(1'b1, 8'd83, 1'b0);
    expect_out("hyst83", 2'd1, 1'b0, 1'b1);
    check("hyst83_raw", 32'(raw_class), 32'd0);
    drive(1'b1, 8'd81, 1'b0);
    expect_out("hyst81", 2'd0, 1'b1, 1'b1);

    // Dwell 2 with an interrupted run
    dwell_cfg = 4'd2;
    drive(1'b1, 8'd100, 1'b0); expect_out("dw1", 2'd0, 1'b0, 1'b1);
    drive(1'b1, 8'd100, 1'b0); expect_out("dw2", 2'd0, 1'b0, 1'b1);
    drive(1'b1, 8'd40,  1'b0); expect_out("dw3", 2'd0, 1'b0, 1'b1);
    drive(1'b1, 8'd100, 1'b0); expect_out("dw4", 2'd0, 1'b0, 1'b1);
    drive(1'b1, 8'd100, 1'b0); expect_out("dw5", 2'd0, 1'b0, 1'b1);
    drive(1'b1, 8'd100, 1'b0); expect_out("dw6", 2'd1, 1'b1, 1'b1);
    drive(1'b0, 8'd100, 1'b0); expect_out("dw7", 2'd1, 1'b0, 1'b1);

    // Alarm: clear coinciding with CRIT commit loses to the set
    dwell_cfg = 4'd0;
    drive(1'b1, 8'd171, 1'b1);
    expect_out("clrset", 2'd2, 1'b1, 1'b1);
    check("clrset_peak", 32'(peak_entropy), 32'(pk(8'd171)));
    drive(1'b0, 8'd0, 1'b1);
    expect_out("clr", 2'd2, 1'b0, 1'b0);
    check("clr_peak", 32'(peak_entropy), 32'd0);

    // Misordered thresholds: MID unreachable
    drive(1'b1, 8'd10, 1'b0);
    expect_out("c2l", 2'd0, 1'b1, 1'b0);
    thr_mid = 8'd200;
    thr_crit = 8'd100;
    drive(1'b1, 8'd201, 1'b0);
    expect_out("mis201", 2'd2, 1'b1, 1'b1);
    check("mis201_raw", 32'(raw_class), 32'd2);

    // Clamp of thr_mid - HYST at zero
    thr_mid = 8'd2;
    thr_crit = 8'd170;
    drive(1'b1, 8'd50, 1'b0);
    expect_out("c2m_b", 2'd1, 1'b1, 1'b1);
    drive(1'b1, 8'd100, 1'b0);
    expect_out("clamp100", 2'd1, 1'b0, 1'b1);
    drive(1'b1, 8'd0, 1'b0);
    expect_out("clamp0", 2'd0, 1'b1, 1'b1);
    check("pre_rst_peak", 32'(peak_entropy), 32'(pk(8'd201)));

    // Async reset mid-dwell
    thr_mid = 8'd85;
    dwell_cfg = 4'd2;
    drive(1'b1, 8'd100, 1'b0);
    expect_out("mid_dwell", 2'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_out("arst", 2'd0, 1'b0, 1'b0);
    check("arst_raw",  32'(raw_class),    32'd0);
    check("arst_peak", 32'(peak_entropy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'd50, 1'b0); expect_out("r50", 2'd0, 1'b0, 1'b0);
    drive(1'b1, 8'd90, 1'b0); expect_out("r90", 2'd0, 1'b0, 1'b0);
    check("r90_raw", 32'(raw_class), 32'd1);
    drive(1'b1, 8'd30, 1'b0); expect_out("r30", 2'd0, 1'b0, 1'b0);
    check("r30_raw",  32'(raw_class),    32'd0);
    check("r30_peak", 32'(peak_entropy), 32'(pk(8'd90)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
